// File: rtl/drr_pkt_queues.sv
// drr_pkt_queues: per-queue packet-size FIFOs serving a DRR scheduler; define DRR_PKTQ_ERR_EN to add sticky err_o
module drr_pkt_queues #(
  parameter int PKT_QS_CNT  = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                                clk_i,
  input  logic                                arst_n_i,
  input  logic                                wr_val_i,
  input  logic [$clog2(PKT_QS_CNT)-1:0]       wr_addr_i,
  input  logic [15:0]                         wr_size_i,
  output logic                                wr_rdy_o,
  input  logic [$clog2(PKT_QS_CNT)-1:0]       read_i,
  input  logic                                read_val_i,
  output logic [PKT_QS_CNT-1:0][15:0]         size_o,
  output logic [PKT_QS_CNT-1:0]               empty_o
`ifdef DRR_PKTQ_ERR_EN
  ,
  output logic [1:0]                          err_o
`endif
);
  localparam int AW = $clog2(PKT_QS_CNT);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  logic [15:0]           mem    [PKT_QS_CNT][QUEUE_DEPTH];
  logic [PW-1:0]         wr_ptr [PKT_QS_CNT];
  logic [PW-1:0]         rd_ptr [PKT_QS_CNT];
  logic [CW-1:0]         cnt    [PKT_QS_CNT];
  logic [PKT_QS_CNT-1:0] full, empty, we, re;
  logic                  wr_acc, rd_acc;
  // zero-size writes are refused so size 0 always means "no packet" downstream
  assign wr_acc   = wr_val_i && !full[wr_addr_i] && (wr_size_i != 16'd0);
  assign rd_acc   = read_val_i && !empty[read_i];
  assign wr_rdy_o = !full[wr_addr_i];
  assign empty_o  = empty;
  // per-queue status, head output and one-hot enqueue/dequeue strobes
  always_comb begin
    full   = '0;
    empty  = '0;
    we     = '0;
    re     = '0;
    size_o = '0;
    for (int q = 0; q < PKT_QS_CNT; q++) begin
      full[q]   = cnt[q] == CW'(QUEUE_DEPTH);
      empty[q]  = cnt[q] == '0;
      we[q]     = wr_acc && (wr_addr_i == AW'(q));
      re[q]     = rd_acc && (read_i == AW'(q));
      size_o[q] = empty[q] ? 16'd0 : mem[q][rd_ptr[q]];
    end
  end
  // storage is not reset; stale entries are masked by cnt
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_addr_i][wr_ptr[wr_addr_i]] <= wr_size_i;
  end
  // pointers and occupancy; a same-cycle push and pop on one queue cancel in cnt
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        cnt[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        if (we[q]) wr_ptr[q] <= wr_ptr[q] + PW'(1);
        if (re[q]) rd_ptr[q] <= rd_ptr[q] + PW'(1);
        cnt[q] <= cnt[q] + CW'(we[q]) - CW'(re[q]);
      end
    end
  end
`ifdef DRR_PKTQ_ERR_EN
  // sticky flags: [0] refused enqueue, [1] dequeue of an empty queue
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) err_o <= '0;
    else err_o <= err_o | {read_val_i && empty[read_i], wr_val_i && !wr_acc};
  end
`endif
endmodule

// File: tb/tb_drr_pkt_queues.sv
// tb_drr_pkt_queues: randomized and directed checks of drr_pkt_queues against a queue-based model
module tb_drr_pkt_queues;
  logic             clk = 0;
  logic             arst_n = 0;
  logic             wr_val = 0;
  logic [1:0]       wr_addr = 0;
  logic [15:0]      wr_size = 0;
  logic             wr_rdy;
  logic [1:0]       rd_q = 0;
  logic             rd_val = 0;
  logic [3:0][15:0] size;
  logic [3:0]       empty;
`ifdef DRR_PKTQ_ERR_EN
  logic [1:0]       err;
`endif
  int               checks = 0;
  int               errors = 0;
  int               mq[4][$];
  logic [1:0]       err_m = 0;

  drr_pkt_queues #(.PKT_QS_CNT(4), .QUEUE_DEPTH(8)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .wr_val_i(wr_val), .wr_addr_i(wr_addr),
    .wr_size_i(wr_size), .wr_rdy_o(wr_rdy), .read_i(rd_q), .read_val_i(rd_val),
    .size_o(size), .empty_o(empty)
`ifdef DRR_PKTQ_ERR_EN
    , .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic int head(input int q);
    return mq[q].size() > 0 ? mq[q][0] : 0;
  endfunction

  // one clock of stimulus; the model applies the FIFO rules using pre-cycle occupancy
  task automatic step(input logic wv, input logic [1:0] wa, input logic [15:0] ws,
                      input logic rv, input logic [1:0] ra);
    bit wacc, racc;
    @(negedge clk);
    wr_val = wv; wr_addr = wa; wr_size = ws; rd_val = rv; rd_q = ra;
    wacc = wv && mq[wa].size() < 8 && ws != 0;
    racc = rv && mq[ra].size() > 0;
    if (wv && !wacc) err_m[0] = 1'b1;
    if (rv && !racc) err_m[1] = 1'b1;
    @(posedge clk);
    if (racc) void'(mq[ra].pop_front());
    if (wacc) mq[wa].push_back(int'(ws));
    #1;
    wr_val = 0; rd_val = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (size !== '0) begin errors++; $display("FAIL reset_size: got %h expected 0", size); end
    checks++; if (empty !== 4'hf) begin errors++; $display("FAIL reset_empty: got %b expected 1111", empty); end
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", wr_rdy); end
`ifdef DRR_PKTQ_ERR_EN
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
`endif
    @(negedge clk);
    arst_n = 1;
  endtask

  task automatic test_single;
    step(1, 2, 100, 0, 0);
    checks++; if (size[2] !== 16'd100) begin errors++; $display("FAIL single_size2: got %0d expected 100", size[2]); end
    checks++; if (empty !== 4'b1011) begin errors++; $display("FAIL single_empty: got %b expected 1011", empty); end
    for (int q = 0; q < 4; q++)
      if (q != 2) begin
        checks++; if (size[q] !== 16'd0) begin errors++; $display("FAIL single_other q%0d: got %0d expected 0", q, size[q]); end
      end
    step(0, 0, 0, 1, 2);
  endtask

  task automatic test_fifo_order;
    int exp[4] = '{300, 200, 64, 0};
    step(1, 1, 300, 0, 0);
    step(1, 1, 200, 0, 0);
    step(1, 1, 64, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (size[1] !== 16'(exp[i])) begin errors++; $display("FAIL fifo_pop%0d: got %0d expected %0d", i, size[1], exp[i]); end
      if (i < 3) step(0, 0, 0, 1, 1);
    end
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL fifo_empty: got %b expected 1", empty[1]); end
  endtask

  task automatic test_full;
    for (int i = 1; i <= 8; i++) step(1, 0, 16'(i), 0, 0);
    wr_addr = 0; #1;
    checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b expected 0", wr_rdy); end
    step(1, 0, 9, 0, 0);
`ifdef DRR_PKTQ_ERR_EN
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL full_err0: got %b expected 1", err[0]); end
`endif
    for (int i = 1; i <= 8; i++) begin
      checks++; if (size[0] !== 16'(i)) begin errors++; $display("FAIL full_drain%0d: got %0d expected %0d", i, size[0], i); end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (empty[0] !== 1'b1 || size[0] !== 16'd0) begin errors++; $display("FAIL full_after: got empty=%b size=%0d expected 1/0", empty[0], size[0]); end
  endtask

  task automatic test_same_cycle;
    for (int i = 0; i < 8; i++) step(1, 3, 16'(10 + i), 0, 0);
    step(1, 3, 50, 1, 3);
    wr_addr = 3; #1;
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL same_full_rdy: got %b expected 1", wr_rdy); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (size[3] !== 16'(10 + i)) begin errors++; $display("FAIL same_full_drain%0d: got %0d expected %0d", i, size[3], 10 + i); end
      step(0, 0, 0, 1, 3);
    end
    checks++; if (empty[3] !== 1'b1) begin errors++; $display("FAIL same_full_dropped: got empty=%b expected 1", empty[3]); end
    step(1, 3, 40, 1, 3);
    checks++; if (size[3] !== 16'd40 || empty[3] !== 1'b0) begin errors++; $display("FAIL same_empty: got size=%0d empty=%b expected 40/0", size[3], empty[3]); end
`ifdef DRR_PKTQ_ERR_EN
    checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL same_empty_err1: got %b expected 1", err[1]); end
`endif
    step(0, 0, 0, 1, 3);
  endtask

  task automatic test_zero_size;
    step(1, 1, 0, 0, 0);
    checks++; if (empty[1] !== 1'b1 || size[1] !== 16'd0) begin errors++; $display("FAIL zero_size: got empty=%b size=%0d expected 1/0", empty[1], size[1]); end
`ifdef DRR_PKTQ_ERR_EN
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL zero_err0: got %b expected 1", err[0]); end
`endif
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0 ? 16'd0 : 16'($urandom_range(1, 65535)),
           $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      for (int q = 0; q < 4; q++) begin
        checks++; if (size[q] !== 16'(head(q))) begin errors++; $display("FAIL rand_size n%0d q%0d: got %0d expected %0d", n, q, size[q], head(q)); end
        checks++; if (empty[q] !== (mq[q].size() == 0)) begin errors++; $display("FAIL rand_empty n%0d q%0d: got %b expected %b", n, q, empty[q], mq[q].size() == 0); end
      end
      wr_addr = 2'($urandom_range(0, 3)); #1;
      checks++; if (wr_rdy !== (mq[wr_addr].size() < 8)) begin errors++; $display("FAIL rand_rdy n%0d: got %b expected %b", n, wr_rdy, mq[wr_addr].size() < 8); end
`ifdef DRR_PKTQ_ERR_EN
      checks++; if (err !== err_m) begin errors++; $display("FAIL rand_err n%0d: got %b expected %b", n, err, err_m); end
`endif
    end
  endtask

  task automatic test_async_reset;
    step(1, 0, 7, 0, 0);
    step(1, 1, 8, 0, 0);
    #2;
    arst_n = 0;
    #1;
    checks++; if (size !== '0) begin errors++; $display("FAIL arst_size: got %h expected 0", size); end
    checks++; if (empty !== 4'hf) begin errors++; $display("FAIL arst_empty: got %b expected 1111", empty); end
`ifdef DRR_PKTQ_ERR_EN
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL arst_err: got %b expected 00", err); end
`endif
    for (int q = 0; q < 4; q++) mq[q].delete();
    err_m = 0;
    @(negedge clk);
    arst_n = 1;
    step(1, 2, 1234, 0, 0);
    checks++; if (size[2] !== 16'd1234 || empty !== 4'b1011) begin errors++; $display("FAIL arst_resume: got size=%0d empty=%b expected 1234/1011", size[2], empty); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fifo_order;
    test_full;
    test_same_cycle;
    test_zero_size;
    test_random;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
